// File: rtl/display_driver.sv
// display_driver: converts an 8-bit value to decimal with a sequential double-dabble engine and scans a 4-digit 7-segment display.
// Optional build macro DISPLAY_HEX_EN adds the hex_mode input for a direct hexadecimal display.
module display_driver #(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] data_i,
    input  logic       load,
    input  logic       signed_mode,
`ifdef DISPLAY_HEX_EN
    input  logic       hex_mode,
`endif
    output logic       busy,
    output logic [6:0] seg_o,
    output logic [3:0] dig_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift {bcd, mag} left.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int n = 0; n < 3; n++) begin
            if (t[8+4*n +: 4] >= 4'd5)
                t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    state_t      state, state_next;
    logic [2:0]  step_cnt;
    logic        pend, pend_signed, pend_hex;
    logic [7:0]  pend_data;
    logic        hex_in, use_pend, start;
    logic [7:0]  src_data;
    logic signed [7:0] src_val;
    logic        src_signed, src_hex, neg_in;
    logic [7:0]  mag_in, mag;
    logic [11:0] bcd;
    logic        cur_neg, cur_hex;
    logic [3:0]  disp_ones, disp_tens, disp_hund;
    logic        disp_neg, disp_hex;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]  scan_idx;
    logic [6:0]  scan_seg;

`ifdef DISPLAY_HEX_EN
    assign hex_in = hex_mode;
`else
    assign hex_in = 1'b0;
`endif

    // A load arriving on the COMMIT edge is newer than any pending request.
    assign use_pend   = (state == COMMIT) && !load && pend;
    assign src_data   = use_pend ? pend_data   : data_i;
    assign src_signed = use_pend ? pend_signed : signed_mode;
    assign src_hex    = use_pend ? pend_hex    : hex_in;
    assign src_val    = src_data;
    assign neg_in     = src_signed && src_data[7] && !src_hex;
    assign mag_in     = neg_in ? 8'(-src_val) : src_data;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE:    start = load;
            SHIFT:   if (step_cnt == 3'd7) state_next = COMMIT;
            COMMIT:  begin
                state_next = IDLE;
                start      = load || pend;
            end
            default: state_next = IDLE;
        endcase
        if (start)
            state_next = src_hex ? COMMIT : SHIFT;
    end

    // Conversion datapath: operand capture and shift steps
    always_ff @(posedge clk) begin
        if (start) begin
            mag     <= mag_in;
            bcd     <= '0;
            cur_neg <= neg_in;
            cur_hex <= src_hex;
        end else if (state == SHIFT) begin
            {bcd, mag} <= dabble_step({bcd, mag});
        end
        if (load && !start) begin
            pend_data   <= data_i;
            pend_signed <= signed_mode;
            pend_hex    <= hex_in;
        end
    end

    // Control and committed display registers
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            step_cnt  <= 3'd0;
            pend      <= 1'b0;
            disp_ones <= 4'd0;
            disp_tens <= 4'd0;
            disp_hund <= 4'd0;
            disp_neg  <= 1'b0;
            disp_hex  <= 1'b0;
        end else begin
            state    <= state_next;
            step_cnt <= (state == SHIFT) ? step_cnt + 3'd1 : 3'd0;
            if (start)
                pend <= 1'b0;
            else if (load)
                pend <= 1'b1;
            if (state == COMMIT) begin
                disp_hex <= cur_hex;
                disp_neg <= cur_neg;
                if (cur_hex) begin
                    disp_ones <= mag[3:0];
                    disp_tens <= mag[7:4];
                    disp_hund <= 4'd0;
                end else begin
                    disp_ones <= bcd[3:0];
                    disp_tens <= bcd[7:4];
                    disp_hund <= bcd[11:8];
                end
            end
        end
    end

    always_comb begin
        scan_seg = 7'h00;
        case (scan_idx)
            2'd0: scan_seg = glyph(disp_ones);
            2'd1: if (disp_hex || disp_hund != 4'd0 || disp_tens != 4'd0) scan_seg = glyph(disp_tens);
            2'd2: if (!disp_hex && disp_hund != 4'd0) scan_seg = glyph(disp_hund);
            default: if (disp_neg) scan_seg = 7'h40;
        endcase
    end

    // Digit scan, registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            dig_o    <= 4'b0001;
            seg_o    <= 7'h3F;
        end else begin
            if (scan_cnt == CNT_MAX) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            dig_o <= 4'b0001 << scan_idx;
            seg_o <= scan_seg;
        end
    end

endmodule

// File: tb/tb_display_driver.sv
// Self-checking bench for display_driver (SCAN_DIV=4); expected glyphs come from integer decimal/hex arithmetic.
module tb_display_driver;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] data_i = 8'd0;
    logic       load = 1'b0;
    logic       signed_mode = 1'b0;
`ifdef DISPLAY_HEX_EN
    logic       hex_mode = 1'b0;
`endif
    logic       busy;
    logic [6:0] seg_o;
    logic [3:0] dig_o;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_driver #(.SCAN_DIV(4)) dut (
        .clk(clk),
        .clr(clr),
        .data_i(data_i),
        .load(load),
        .signed_mode(signed_mode),
`ifdef DISPLAY_HEX_EN
        .hex_mode(hex_mode),
`endif
        .busy(busy),
        .seg_o(seg_o),
        .dig_o(dig_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: expected glyph per digit position (0=ones .. 3=sign).
    function automatic logic [3:0][6:0] expect_disp(input logic [7:0] d, input logic sgn, input logic hx);
        logic [3:0][6:0] e;
        int v, h, t, o;
        logic neg;
        e = '0;
        if (hx) begin
            e[0] = GLYPH[d[3:0]];
            e[1] = GLYPH[d[7:4]];
            return e;
        end
        neg = sgn && (d >= 8'd128);
        v = neg ? 256 - int'(d) : int'(d);
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        e[0] = GLYPH[4'(o)];
        e[1] = (h != 0 || t != 0) ? GLYPH[4'(t)] : 7'h00;
        e[2] = (h != 0) ? GLYPH[4'(h)] : 7'h00;
        e[3] = neg ? 7'h40 : 7'h00;
        return e;
    endfunction

    // Drive one load, then count cycles with busy high (bounded).
    task automatic run_load(input logic [7:0] d, input logic s, input logic hx, output int busy_cnt);
        @(negedge clk);
        data_i = d;
        signed_mode = s;
`ifdef DISPLAY_HEX_EN
        hex_mode = hx;
`else
        if (hx) $display("note: hex request ignored in decimal build");
`endif
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    // Collect the glyph shown for each digit over a full scan rotation.
    task automatic read_display(output logic [3:0][6:0] got);
        got = 'x;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            case (dig_o)
                4'b0001: got[0] = seg_o;
                4'b0010: got[1] = seg_o;
                4'b0100: got[2] = seg_o;
                4'b1000: got[3] = seg_o;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        int idx;
        @(negedge clk);
        clr = 1'b1;
        load = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dig_o !== 4'b0001) begin errors++; $display("FAIL reset_dig: got %b expected 0001", dig_o); end
        checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h expected 3f", seg_o); end
        clr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            idx = ((k - 1) / 4) % 4;
            exp_dig = 4'b0001 << idx;
            exp_seg = (idx == 0) ? 7'h3F : 7'h00;
            checks++;
            if (dig_o !== exp_dig) begin errors++; $display("FAIL scan_dig k=%0d: got %b expected %b", k, dig_o, exp_dig); end
            checks++;
            if (seg_o !== exp_seg) begin errors++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg_o, exp_seg); end
        end
    endtask

    task automatic test_decimal();
        logic [7:0] vals [5] = '{8'd123, 8'd7, 8'hFF, 8'h80, 8'h80};
        logic       sgns [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0][6:0] got, exp;
        int bc;
        for (int n = 0; n < 5; n++) begin
            run_load(vals[n], sgns[n], 1'b0, bc);
            checks++;
            if (bc !== 9) begin errors++; $display("FAIL dec_busy val=%h: got %0d cycles expected 9", vals[n], bc); end
            read_display(got);
            exp = expect_disp(vals[n], sgns[n], 1'b0);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (got[p] !== exp[p]) begin
                    errors++;
                    $display("FAIL dec_digit val=%h signed=%b pos=%0d: got %h expected %h", vals[n], sgns[n], p, got[p], exp[p]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic s;
        logic [3:0][6:0] got, exp;
        int bc;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run_load(d, s, 1'b0, bc);
            checks++;
            if (bc !== 9) begin errors++; $display("FAIL rand_busy val=%h: got %0d cycles expected 9", d, bc); end
            read_display(got);
            exp = expect_disp(d, s, 1'b0);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (got[p] !== exp[p]) begin
                    errors++;
                    $display("FAIL rand_digit val=%h signed=%b pos=%0d: got %h expected %h", d, s, p, got[p], exp[p]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, final_val;
        logic sb, final_sgn;
        logic [3:0][6:0] got, exp;
        int bc;
        for (int sc = 0; sc < 3; sc++) begin
            a  = (sc == 0) ? 8'd5 : 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            sb = (sc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
`ifdef DISPLAY_HEX_EN
            hex_mode = 1'b0;
`endif
            data_i = a;
            signed_mode = 1'b0;
            load = 1'b1;
            bc = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                load = 1'b0;
                if (!busy) break;
                bc++;
                if (sc == 0 && i == 2) begin data_i = 8'd42; load = 1'b1; end
                if (sc == 0 && i == 5) begin data_i = 8'd99; load = 1'b1; end
                if (sc == 1 && i == 4) begin data_i = b; signed_mode = sb; load = 1'b1; end
                if (sc == 2 && i == 8) begin data_i = b; signed_mode = sb; load = 1'b1; end
            end
            final_val = (sc == 0) ? 8'd99 : b;
            final_sgn = (sc == 0) ? 1'b0 : sb;
            checks++;
            if (bc !== 18) begin errors++; $display("FAIL b2b_busy scenario=%0d: got %0d cycles expected 18", sc, bc); end
            read_display(got);
            exp = expect_disp(final_val, final_sgn, 1'b0);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (got[p] !== exp[p]) begin
                    errors++;
                    $display("FAIL b2b_digit scenario=%0d pos=%0d: got %h expected %h", sc, p, got[p], exp[p]);
                end
            end
        end
    endtask

    task automatic test_clr_mid();
        logic [3:0][6:0] got;
        logic [3:0][6:0] exp;
        int late_busy;
        @(negedge clk);
        data_i = 8'd200;
        signed_mode = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (i == 3) clr = 1'b1;
            if (i == 4) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b expected 0", busy); end
                checks++; if (dig_o !== 4'b0001) begin errors++; $display("FAIL clr_dig: got %b expected 0001", dig_o); end
                checks++; if (seg_o !== 7'h3F) begin errors++; $display("FAIL clr_seg: got %h expected 3f", seg_o); end
                clr = 1'b0;
            end
        end
        late_busy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) late_busy++;
        end
        checks++;
        if (late_busy !== 0) begin errors++; $display("FAIL clr_late_busy: got %0d busy cycles expected 0", late_busy); end
        read_display(got);
        exp = '0;
        exp[0] = 7'h3F;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (got[p] !== exp[p]) begin errors++; $display("FAIL clr_digit pos=%0d: got %h expected %h", p, got[p], exp[p]); end
        end
    endtask

`ifdef DISPLAY_HEX_EN
    task automatic test_hex();
        logic [7:0] d;
        logic s;
        logic [3:0][6:0] got, exp;
        int bc;
        for (int n = 0; n < 4; n++) begin
            d = (n == 0) ? 8'hAB : 8'($urandom_range(0, 255));
            s = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            run_load(d, s, 1'b1, bc);
            checks++;
            if (bc !== 1) begin errors++; $display("FAIL hex_busy val=%h: got %0d cycles expected 1", d, bc); end
            read_display(got);
            exp = expect_disp(d, s, 1'b1);
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (got[p] !== exp[p]) begin
                    errors++;
                    $display("FAIL hex_digit val=%h pos=%0d: got %h expected %h", d, p, got[p], exp[p]);
                end
            end
        end
        hex_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_decimal();
        test_random();
        test_back_to_back();
        test_clr_mid();
`ifdef DISPLAY_HEX_EN
        test_hex();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
